// File: rtl/afp3_fifo_pkg.sv
// afp3_fifo_pkg: shared sizing constants for the AFP FIFO controllers
package afp3_fifo_pkg;
  localparam int FIFO_AW    = 10;
  localparam int FIFO_DW    = 18;
  localparam int FIFO_DEPTH = 1024;
  localparam int OB_DEPTH   = 2;
  localparam int CNT_W      = 11;
endpackage

// File: rtl/afp3_fifo_obuf.sv
// afp3_fifo_obuf: 2-entry first-word-fall-through output buffer with head/tail, load/pop/clear
module afp3_fifo_obuf
  import afp3_fifo_pkg::*;
#(
  parameter int DW = FIFO_DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          pop,
  output logic [DW-1:0] data,
  output logic          valid,
  output logic [1:0]    cnt
);
  logic [DW-1:0] ob_q [OB_DEPTH];
  logic [DW-1:0] ob_d [OB_DEPTH];
  logic          head_q, head_d, tail;
  logic [1:0]    cnt_q, cnt_d;
  logic          ld, pp;
  // next entry contents, head and occupancy; head stays put when the last word leaves so data holds
  always_comb begin
    ld     = load & ~clear;
    pp     = pop & ~clear;
    tail   = head_q ^ cnt_q[0];
    ob_d   = ob_q;
    if (ld) ob_d[tail] = load_data;
    cnt_d  = clear ? 2'd0 : cnt_q + 2'(ld) - 2'(pp);
    head_d = (pp && (cnt_q != 2'd1 || ld)) ? ~head_q : head_q;
  end
  // buffer state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ob_q   <= '{default: '0};
      head_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      ob_q   <= ob_d;
      head_q <= head_d;
      cnt_q  <= cnt_d;
    end
  end
  assign data  = ob_q[head_q];
  assign valid = cnt_q != 2'd0;
  assign cnt   = cnt_q;
endmodule

// File: rtl/afp3_fifo1024x018_ctl.sv
// afp3_fifo1024x018_ctl: valid/ready FWFT FIFO controller around a 1024x18 simple-dual-port RAM
module afp3_fifo1024x018_ctl
  import afp3_fifo_pkg::*;
#(
  parameter int AFULL_LVL  = 1000,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [FIFO_DW-1:0]   wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [FIFO_DW-1:0]   rd_data,
  output logic [CNT_W-1:0]     count,
  output logic                 almost_full,
  output logic                 almost_empty
);
  logic [FIFO_DW-1:0] mem [FIFO_DEPTH];
  logic [FIFO_DW-1:0] ram_q;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   ram_cnt_q, ram_cnt_d, count_q, count_d;
  logic               rd_pend_q, rd_pend_d, afull_q, afull_d, aempty_q, aempty_d;
  logic               push, pop, wren, rden, load;
  logic [1:0]         ob_cnt, ob_cnt_d;
  // handshakes, prefetch issue and next-state; issue only when the buffer has room after this cycle's pop
  always_comb begin
    wr_ready  = (ram_cnt_q != CNT_W'(FIFO_DEPTH)) && !flush;
    push      = wr_valid && wr_ready;
    pop       = rd_valid && rd_ready && !flush;
    rden      = (ram_cnt_q != '0) && ((3'(ob_cnt) + 3'(rd_pend_q) - 3'(pop)) < 3'(OB_DEPTH)) && !flush;
    wren      = push;
    load      = rd_pend_q && !flush;
    wr_ptr_d  = flush ? '0 : wr_ptr_q + FIFO_AW'(push);
    rd_ptr_d  = flush ? '0 : rd_ptr_q + FIFO_AW'(rden);
    ram_cnt_d = flush ? '0 : ram_cnt_q + CNT_W'(push) - CNT_W'(rden);
    rd_pend_d = rden;
    ob_cnt_d  = flush ? 2'd0 : ob_cnt + 2'(load) - 2'(pop);
    count_d   = ram_cnt_d + CNT_W'(rd_pend_d) + CNT_W'(ob_cnt_d);
    afull_d   = count_d >= CNT_W'(AFULL_LVL);
    aempty_d  = count_d <= CNT_W'(AEMPTY_LVL);
  end
  // pointer, occupancy and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      count_q   <= '0;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= rd_pend_d;
      count_q   <= count_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
    end
  end
  // block RAM: registered read gated by rden; a read never targets the address being written
  always_ff @(posedge clk) begin
    if (wren) mem[wr_ptr_q] <= wr_data;
    if (rden) ram_q <= mem[rd_ptr_q];
    if (wren && rden) assert (wr_ptr_q != rd_ptr_q);
  end
  afp3_fifo_obuf #(.DW(FIFO_DW)) u_obuf (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (flush),
    .load      (load),
    .load_data (ram_q),
    .pop       (pop),
    .data      (rd_data),
    .valid     (rd_valid),
    .cnt       (ob_cnt)
  );
  assign count        = count_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
endmodule

// File: tb/tb_afp3_fifo1024x018_ctl.sv
// tb_afp3_fifo1024x018_ctl: directed and streaming checks of the FWFT FIFO controller against a queue model
module tb_afp3_fifo1024x018_ctl;
  logic        clk = 1'b0;
  logic        reset_n, flush, wr_valid, wr_ready, rd_valid, rd_ready, almost_full, almost_empty;
  logic [17:0] wr_data, rd_data;
  logic [10:0] count;
  logic [17:0] q [$];
  logic        did_push;
  int          n_chk = 0, n_pass = 0, pushed, tries;

  always #5 clk = ~clk;

  afp3_fifo1024x018_ctl dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // one clock: drive, resolve handshakes mid-cycle, update model, then check count and flags
  task automatic cycle(input logic wv, input logic [17:0] wd, input logic rr);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    @(negedge clk);
    did_push = wv & wr_ready;
    if (rd_valid && rr) begin
      if (q.size() == 0) chk("spurious_valid", 32'(rd_valid), 32'd0);
      else chk("order", 32'(rd_data), 32'(q.pop_front()));
    end
    if (did_push) q.push_back(wd);
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(q.size()));
    chk("afull", 32'(almost_full), 32'(q.size() >= 1000));
    chk("aempty", 32'(almost_empty), 32'(q.size() <= 2));
  endtask

  task automatic push_word(input logic [17:0] d);
    did_push = 1'b0;
    for (int t = 0; t < 8 && !did_push; t++) cycle(1'b1, d, 1'b0);
    if (!did_push) chk("push_timeout", 32'(did_push), 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && q.size() != 0; t++) cycle(1'b0, '0, 1'b1);
    chk("drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    #23;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    // idle: nothing issued to the RAM
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1);
      chk("idle_rden", 32'(dut.rden), 32'd0);
      chk("idle_valid", 32'(rd_valid), 32'd0);
    end
    // single word latency: valid two edges after the push edge
    cycle(1'b1, 18'h00001, 1'b0);
    chk("lat_e0", 32'(rd_valid), 32'd0);
    cycle(1'b0, '0, 1'b0);
    chk("lat_e1", 32'(rd_valid), 32'd0);
    cycle(1'b0, '0, 1'b0);
    chk("lat_e2", 32'(rd_valid), 32'd1);
    chk("lat_data", 32'(rd_data), 32'h1);
    chk("lat_count1", 32'(count), 32'd1);
    cycle(1'b0, '0, 1'b1);
    chk("lat_count0", 32'(count), 32'd0);
    chk("lat_hold", 32'(rd_data), 32'h1);
    // fill to 1026 with no reads, then check full behaviour and drain in order
    for (int i = 0; i < 1026; i++) push_word(18'(i));
    repeat (3) cycle(1'b0, '0, 1'b0);
    chk("full_count", 32'(count), 32'd1026);
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    chk("full_afull", 32'(almost_full), 32'd1);
    chk("full_head", 32'(rd_data), 32'd0);
    cycle(1'b1, 18'h2AAAA, 1'b0);
    chk("full_push_ignored", 32'(did_push), 32'd0);
    drain();
    // simultaneous push+pop at count 1
    push_word(18'h12345);
    repeat (3) cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 18'h0ABCD, 1'b1);
    chk("pp1_push", 32'(did_push), 32'd1);
    chk("pp1_count", 32'(count), 32'd1);
    repeat (3) cycle(1'b0, '0, 1'b0);
    chk("pp1_head", 32'(rd_data), 32'h0ABCD);
    drain();
    // push+pop at full: only the pop lands, order continues
    for (int i = 0; i < 1026; i++) push_word(18'(i + 1000));
    repeat (3) cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 18'h3C3C3, 1'b1);
    chk("ppf_count", 32'(count), 32'd1025);
    cycle(1'b1, 18'h3C3C3, 1'b1);
    cycle(1'b1, 18'h3C3C4, 1'b0);
    drain();
    // random streaming across several pointer wraps
    pushed = 0;
    tries = 0;
    while ((pushed < 5000 || q.size() != 0) && tries < 40000) begin
      cycle(pushed < 5000 && $urandom_range(1) == 1, 18'($urandom), $urandom_range(1) == 1);
      if (did_push) pushed++;
      tries++;
    end
    chk("stream_pushed", 32'(pushed), 32'd5000);
    chk("stream_empty", 32'(q.size()), 32'd0);
    // flush with a RAM read in flight at count 37
    for (int i = 0; i < 38; i++) push_word(18'(i + 500));
    repeat (3) cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("fl_count37", 32'(count), 32'd37);
    chk("fl_inflight", 32'(dut.rd_pend_q), 32'd1);
    flush = 1'b1; wr_valid = 1'b1; wr_data = 18'h11111; rd_ready = 1'b1;
    @(negedge clk);
    chk("fl_wr_ready", 32'(wr_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    q.delete();
    chk("fl_count0", 32'(count), 32'd0);
    chk("fl_valid0", 32'(rd_valid), 32'd0);
    chk("fl_aempty", 32'(almost_empty), 32'd1);
    cycle(1'b1, 18'h3FFFF, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0);
    chk("fl_valid1", 32'(rd_valid), 32'd1);
    chk("fl_data", 32'(rd_data), 32'h3FFFF);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
